// File: rtl/podium_entry_collector_pkg.sv
// Package: podium_entry_collector_pkg
// Purpose: Shared types and constants for the podium entry collector.
//   Holds the FSM state encoding and frame geometry. The permutation checker
//   downstream uses the same frame geometry.
// Contents:
//   state_t       - collector FSM states (COLLECT = 1'b0, FULL = 1'b1)
//   PODIUM_SLOTS  - places per frame (4)
//   PODIUM_ID_W   - finisher ID width (2)
package podium_entry_collector_pkg;

  localparam int PODIUM_SLOTS = 4;
  localparam int PODIUM_ID_W  = 2;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

endpackage

// File: rtl/podium_slot_store.sv
// Module: podium_slot_store
// Purpose: 4-entry register file holding the places of the current frame.
//   Supports one write per cycle and a synchronous clear of all slots.
//   When PODIUM_DUP_REJECT_EN is defined, it also reports whether a query ID
//   is already held in one of the filled slots.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   clr               - synchronous clear of all slots
//   wr_en, wr_idx     - write enable and slot index
//   wr_id             - ID to store
//   N0..N3            - slot contents
//   fill, query       - (PODIUM_DUP_REJECT_EN) filled-slot count and ID to look up
//   present           - (PODIUM_DUP_REJECT_EN) query matches a filled slot
module podium_slot_store
  import podium_entry_collector_pkg::*;
#(
  parameter int ID_W = PODIUM_ID_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [1:0]      wr_idx,
  input  logic [ID_W-1:0] wr_id,
`ifdef PODIUM_DUP_REJECT_EN
  input  logic [2:0]      fill,
  input  logic [ID_W-1:0] query,
  output logic            present,
`endif
  output logic [ID_W-1:0] N0,
  output logic [ID_W-1:0] N1,
  output logic [ID_W-1:0] N2,
  output logic [ID_W-1:0] N3
);

  logic [ID_W-1:0] slot [PODIUM_SLOTS];

  // Slot register file: reset/clear wipes every place, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < PODIUM_SLOTS; i++) begin
        slot[i] <= '0;
      end
    end else if (wr_en) begin
      slot[wr_idx] <= wr_id;
    end else begin
      slot <= slot;
    end
  end

`ifdef PODIUM_DUP_REJECT_EN
  // Duplicate lookup: only slots below the fill level hold real entries.
  always_comb begin
    present = 1'b0;
    for (int i = 0; i < PODIUM_SLOTS; i++) begin
      present = present | ((3'(i) < fill) && (slot[i] == query));
    end
  end
`endif

  assign N0 = slot[0];
  assign N1 = slot[1];
  assign N2 = slot[2];
  assign N3 = slot[3];

endmodule

// File: rtl/podium_entry_collector.sv
// Module: podium_entry_collector
// Purpose: Collects four finisher IDs over a valid/ready handshake into a
//   podium frame (places 1st..4th) and presents it until the consumer takes it.
//   A partially filled frame is discarded after TIMEOUT idle cycles.
// Configuration macro: PODIUM_DUP_REJECT_EN - when defined, an ID that is
//   already in the frame is consumed but not stored, and dup_err pulses.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid/in_ready    - input handshake, in_id is the next place's finisher
//   out_valid/out_ready  - frame handshake, N0..N3 hold the frame
//   count                - places filled so far (0..4)
//   abort                - one-cycle pulse, partial frame dropped by timeout
//   dup_err              - one-cycle pulse, duplicate ID dropped
// Timing: abort and dup_err are registered, so each pulse appears in the cycle
//   after the cycle that causes it, together with the updated count.
module podium_entry_collector
  import podium_entry_collector_pkg::*;
#(
  parameter int ID_W    = PODIUM_ID_W,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] N0,
  output logic [ID_W-1:0] N1,
  output logic [ID_W-1:0] N2,
  output logic [ID_W-1:0] N3,
  output logic [2:0]      count,
  output logic            abort,
  output logic            dup_err
);

  state_t          state, state_next;
  logic [2:0]      count_next;
  logic [TO_W-1:0] timer, timer_next;
  logic            abort_next, dup_next;
  logic            accept, is_dup, store_en, clr, counting, expire;

`ifdef PODIUM_DUP_REJECT_EN
  logic id_present;
`endif

  podium_slot_store #(.ID_W(ID_W)) u_store (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (store_en),
    .wr_idx  (count[1:0]),
    .wr_id   (in_id),
`ifdef PODIUM_DUP_REJECT_EN
    .fill    (count),
    .query   (in_id),
    .present (id_present),
`endif
    .N0      (N0),
    .N1      (N1),
    .N2      (N2),
    .N3      (N3)
  );

  // Handshake decode and timeout expiry detection.
  always_comb begin
    in_ready = (state == ST_COLLECT) && !rst;
    accept   = in_valid && in_ready;
`ifdef PODIUM_DUP_REJECT_EN
    is_dup   = id_present;
`else
    is_dup   = 1'b0;
`endif
    store_en = accept && !is_dup;
    // The timer only runs while a partial frame waits for more IDs.
    counting = (state == ST_COLLECT) && (count != 3'd0) && !accept;
    expire   = (TIMEOUT != 0) && counting && (timer == TO_W'(TIMEOUT));
  end

  // Next-state, fill count, timer and pulse generation.
  always_comb begin
    state_next = state;
    count_next = count;
    timer_next = timer;
    clr        = 1'b0;
    abort_next = 1'b0;
    dup_next   = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (accept) begin
          // Any accepted ID, even a rejected duplicate, counts as activity.
          timer_next = '0;
          if (store_en) begin
            count_next = count + 3'd1;
            if (count == 3'd3) begin
              state_next = ST_FULL;
            end else begin
              state_next = ST_COLLECT;
            end
          end else begin
            dup_next = 1'b1;
          end
        end else if (expire) begin
          abort_next = 1'b1;
          clr        = 1'b1;
          count_next = 3'd0;
          timer_next = '0;
        end else if (counting && (timer != TO_W'(TIMEOUT))) begin
          timer_next = timer + TO_W'(1);
        end else begin
          timer_next = timer;
        end
      end
      ST_FULL: begin
        timer_next = '0;
        if (out_ready) begin
          state_next = ST_COLLECT;
          count_next = 3'd0;
          clr        = 1'b1;
        end else begin
          state_next = ST_FULL;
        end
      end
      default: begin
        state_next = ST_COLLECT;
        count_next = 3'd0;
        timer_next = '0;
        clr        = 1'b1;
      end
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COLLECT;
      count     <= 3'd0;
      timer     <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      timer     <= timer_next;
      out_valid <= (state_next == ST_FULL);
      abort     <= abort_next;
      dup_err   <= dup_next;
    end
  end

endmodule

// File: tb/tb_podium_entry_collector.sv
module tb_podium_entry_collector;

  localparam int TIMEOUT = 15;
`ifdef PODIUM_DUP_REJECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, abort, dup_err;
  logic [1:0] in_id, N0, N1, N2, N3;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: the frame as a list of arrival-ordered IDs.
  int q[$];
  bit m_full  = 1'b0;
  int m_idle  = 0;
  bit m_abort = 1'b0;
  bit m_dup   = 1'b0;

  podium_entry_collector #(.ID_W(2), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .out_valid(out_valid), .out_ready(out_ready),
    .N0(N0), .N1(N1), .N2(N2), .N3(N3), .count(count),
    .abort(abort), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_frame(input int id);
    foreach (q[i]) if (q[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int slot_exp(input int k);
    return (k < q.size()) ? q[k] : 0;
  endfunction

  // Apply the frame rules for one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic v, input logic [1:0] id, input logic ordy);
    m_abort = 1'b0;
    m_dup   = 1'b0;
    if (r) begin
      q.delete(); m_full = 1'b0; m_idle = 0;
    end else if (m_full) begin
      if (ordy) begin m_full = 1'b0; q.delete(); m_idle = 0; end
    end else if (v) begin
      m_idle = 0;
      if (DUP_EN && in_frame(int'(id))) m_dup = 1'b1;
      else begin
        q.push_back(int'(id));
        if (q.size() == 4) m_full = 1'b1;
      end
    end else if (q.size() != 0) begin
      if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
        m_abort = 1'b1; q.delete(); m_idle = 0;
      end else if (m_idle < TIMEOUT) begin
        m_idle++;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", 8'(out_valid), 8'(m_full));
    chk("count", 8'(count), 8'(q.size()));
    chk("N0", 8'(N0), 8'(slot_exp(0)));
    chk("N1", 8'(N1), 8'(slot_exp(1)));
    chk("N2", 8'(N2), 8'(slot_exp(2)));
    chk("N3", 8'(N3), 8'(slot_exp(3)));
    chk("abort", 8'(abort), 8'(m_abort));
    chk("dup_err", 8'(dup_err), 8'(m_dup));
  endtask

  // One clock cycle: drive, check in_ready mid-cycle, clock, check outputs.
  task automatic step(input logic r, input logic v, input logic [1:0] id, input logic ordy);
    rst = r; in_valid = v; in_id = id; out_ready = ordy;
    #1;
    chk("in_ready", 8'(in_ready), 8'(!m_full && !r));
    @(posedge clk);
    model_edge(r, v, id, ordy);
    #1;
    check_all();
  endtask

  task automatic send4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    step(1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b1, b, 1'b0);
    step(1'b0, 1'b1, c, 1'b0);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_id = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    // Reset state
    step(1'b1, 1'b1, 2'd3, 1'b1);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    chk("rst_count", 8'(count), 8'd0);

    // 1: full frame, held while consumer is not ready and upstream keeps pushing
    send4(2'd2, 2'd0, 2'd3, 2'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 1'b0);
    chk("t1_frame", {N0, N1, N2, N3}, 8'b10_00_11_01);
    chk("t1_out_valid", 8'(out_valid), 8'd1);

    // 2: hand-off, then a second frame, then hand-off
    step(1'b0, 1'b0, 2'd0, 1'b1);
    chk("t2_count", 8'(count), 8'd0);
    send4(2'd3, 2'd2, 2'd1, 2'd0);
    chk("t2_frame", {N0, N1, N2, N3}, 8'b11_10_01_00);
    step(1'b0, 1'b1, 2'd1, 1'b1);

    // 3: partial frame times out after the idle budget
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    idle(TIMEOUT);
    chk("t3_no_early_abort", 8'(abort), 8'd0);
    idle(1);
    chk("t3_abort", 8'(abort), 8'd1);
    chk("t3_frame_clear", {5'd0, count}, 8'd0);
    idle(2);

    // 4: accept on the expiry cycle wins over the abort
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    idle(TIMEOUT);
    step(1'b0, 1'b1, 2'd3, 1'b0);
    chk("t4_no_abort", 8'(abort), 8'd0);
    chk("t4_count", 8'(count), 8'd3);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1);

    // 5: duplicate handling
    step(1'b0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    chk("t5_dup_err", 8'(dup_err), 8'(DUP_EN));
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0);
    chk("t5_frame", {N0, N1, N2, N3}, DUP_EN ? 8'b00_01_10_11 : 8'b00_00_01_10);
    step(1'b0, 1'b0, 2'd0, 1'b1);

    // 6: reset in FULL and mid-frame
    send4(2'd1, 2'd3, 2'd0, 2'd2);
    step(1'b1, 1'b0, 2'd0, 1'b0);
    chk("t6_full_rst", {out_valid, abort, count, 3'd0}, 8'd0);
    step(1'b0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b0);
    chk("t6_mid_rst", {N0, N1, abort, count}, 8'd0);

    // Randomized traffic with occasional long stalls and rare resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        idle(TIMEOUT + 2);
      end else begin
        step(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < 60),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 30));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
